// File: rtl/key_pkg.sv
// key_pkg: shared state encoding for the push-button debounce channels.
package key_pkg;
    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_t;
endpackage

// File: rtl/key_debounce_ch.sv
// key_debounce_ch: one button channel (2-FF sync, debounce FSM, hold counter, pulses).
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int DB_CYCLES   = 500_000,
    parameter int LONG_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw_n,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long
);
    localparam int CW = $clog2(DB_CYCLES);
    localparam int HW = LONG_CYCLES > 0 ? $clog2(LONG_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DB_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
    localparam logic [HW-1:0] HOLD_FIRE = HW'(LONG_CYCLES - 1);
    logic ff1, ff2, pressed_s;
    key_state_t state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [HW-1:0] hold, hold_nxt;
    logic level_nxt, press_nxt, release_nxt, long_nxt;
    assign pressed_s = ~ff2;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff1         <= 1'b1;
            ff2         <= 1'b1;
            state       <= RELEASED;
            cnt         <= '0;
            hold        <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
        end else begin
            ff1         <= key_raw_n;
            ff2         <= ff1;
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            hold        <= hold_nxt;
            key_level   <= level_nxt;
            key_press   <= press_nxt;
            key_release <= release_nxt;
            key_long    <= long_nxt;
        end
    end
    // Hold saturates at LONG_CYCLES so the fire point is crossed only once per press.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        hold_nxt  = hold;
        case (state)
            RELEASED: if (pressed_s) begin
                state_nxt = PRESS_WAIT;
                cnt_nxt   = '0;
            end
            PRESS_WAIT: if (!pressed_s) state_nxt = RELEASED;
                else if (cnt == CNT_LAST) begin
                    state_nxt = PRESSED;
                    hold_nxt  = '0;
                end else cnt_nxt = cnt + CW'(1);
            PRESSED: if (!pressed_s) begin
                state_nxt = RELEASE_WAIT;
                cnt_nxt   = '0;
            end else if (hold != HOLD_MAX) hold_nxt = hold + HW'(1);
            RELEASE_WAIT: if (pressed_s) state_nxt = PRESSED;
                else if (cnt == CNT_LAST) state_nxt = RELEASED;
                else cnt_nxt = cnt + CW'(1);
        endcase
    end
    always_comb begin
        press_nxt   = state == PRESS_WAIT && pressed_s && cnt == CNT_LAST;
        release_nxt = state == RELEASE_WAIT && !pressed_s && cnt == CNT_LAST;
        long_nxt    = LONG_CYCLES != 0 && state == PRESSED && pressed_s && hold == HOLD_FIRE;
        level_nxt   = state_nxt == PRESSED || state_nxt == RELEASE_WAIT;
    end
endmodule

// File: rtl/key_debounce.sv
// key_debounce: N independent debounced push-button channels feeding the timer controls.
module key_debounce #(
    parameter int N_KEYS      = 2,
    parameter int DB_CYCLES   = 500_000,
    parameter int LONG_CYCLES = 50_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key_raw_n,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_long
);
    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .DB_CYCLES  (DB_CYCLES),
            .LONG_CYCLES(LONG_CYCLES)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .key_raw_n  (key_raw_n[i]),
            .key_level  (key_level[i]),
            .key_press  (key_press[i]),
            .key_release(key_release[i]),
            .key_long   (key_long[i])
        );
    end
endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: scenario tasks plus random traffic against a run-length reference model.
module tb_key_debounce;
    localparam int NK = 2, DB = 4, LG = 20;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NK-1:0] key_raw_n = '1;
    logic [NK-1:0] key_level, key_press, key_release, key_long;
    key_debounce #(.N_KEYS(NK), .DB_CYCLES(DB), .LONG_CYCLES(LG)) dut (
        .clk(clk), .rst_n(rst_n), .key_raw_n(key_raw_n),
        .key_level(key_level), .key_press(key_press),
        .key_release(key_release), .key_long(key_long)
    );
    always #5 clk = ~clk;
    int n_cmp = 0, n_err = 0;
    // Model: a key flips once DB+1 consecutive samples disagree with its level;
    // hold counts undisturbed pressed samples while down.
    logic [NK-1:0] d1 = '1, d2 = '1, m_lvl = '0, e_p = '0, e_r = '0, e_l = '0;
    int run [NK];
    int hld [NK];
    task automatic tick();
        logic ps;
        @(posedge clk);
        for (int k = 0; k < NK; k++) begin
            e_p[k] = 1'b0;
            e_r[k] = 1'b0;
            e_l[k] = 1'b0;
            if (!rst_n) begin
                d1[k] = 1'b1; d2[k] = 1'b1; m_lvl[k] = 1'b0; run[k] = 0; hld[k] = 0;
            end else begin
                ps = !d2[k];
                d2[k] = d1[k];
                d1[k] = key_raw_n[k];
                if (ps != m_lvl[k]) begin
                    run[k]++;
                    if (run[k] == DB + 1) begin
                        m_lvl[k] = ps;
                        run[k] = 0;
                        if (ps) begin e_p[k] = 1'b1; hld[k] = 0; end
                        else e_r[k] = 1'b1;
                    end
                end else begin
                    if (m_lvl[k] && run[k] == 0 && hld[k] < LG) begin
                        if (hld[k] == LG - 1) e_l[k] = 1'b1;
                        hld[k]++;
                    end
                    run[k] = 0;
                end
            end
        end
        @(negedge clk);
    endtask
    function automatic logic [4*NK-1:0] obs();
        return {key_level, key_press, key_release, key_long};
    endfunction
    function automatic logic [4*NK-1:0] mdl();
        return {m_lvl, e_p, e_r, e_l};
    endfunction
    task automatic settle();
        key_raw_n = '1;
        repeat (20) tick();
    endtask
    task automatic test_reset();
        rst_n = 1'b0;
        key_raw_n = '1;
        repeat (3) tick();
        n_cmp++;
        if (obs() !== '0) begin n_err++; $display("FAIL reset_state got=%b exp=0", obs()); end
        rst_n = 1'b1;
        settle();
    endtask
    task automatic test_clean_press();
        key_raw_n[0] = 1'b0;
        for (int t = 1; t <= 12; t++) begin
            tick();
            n_cmp += 3;
            if (obs() !== mdl()) begin n_err++; $display("FAIL press_model t=%0d got=%b exp=%b", t, obs(), mdl()); end
            if (key_press[0] !== (t == 7)) begin n_err++; $display("FAIL press_timing t=%0d got=%b", t, key_press[0]); end
            if (key_level[0] !== (t >= 7) || key_long[0] !== 1'b0) begin
                n_err++; $display("FAIL press_level t=%0d level=%b long=%b", t, key_level[0], key_long[0]);
            end
        end
        key_raw_n[0] = 1'b1;
        for (int t = 1; t <= 9; t++) begin
            tick();
            n_cmp += 2;
            if (obs() !== mdl()) begin n_err++; $display("FAIL release_model t=%0d got=%b exp=%b", t, obs(), mdl()); end
            if (key_release[0] !== (t == 7) || key_level[0] !== (t < 7)) begin
                n_err++; $display("FAIL release_timing t=%0d rel=%b level=%b", t, key_release[0], key_level[0]);
            end
        end
        settle();
    endtask
    task automatic test_bounce();
        logic [15:0] pat;
        pat = 16'b1111111111_100100;
        for (int t = 0; t < 16; t++) begin
            key_raw_n[0] = pat[t];
            tick();
            n_cmp += 2;
            if (obs() !== mdl()) begin n_err++; $display("FAIL bounce_model t=%0d got=%b exp=%b", t, obs(), mdl()); end
            if (key_press[0] !== 1'b0 || key_level[0] !== 1'b0) begin
                n_err++; $display("FAIL bounce_nopress t=%0d press=%b level=%b", t, key_press[0], key_level[0]);
            end
        end
        settle();
    endtask
    task automatic test_long_press();
        int pt, lt, nl, rt;
        pt = -1; lt = -1; nl = 0; rt = -1;
        key_raw_n[0] = 1'b0;
        for (int t = 1; t <= 40; t++) begin
            tick();
            n_cmp++;
            if (obs() !== mdl()) begin n_err++; $display("FAIL long_model t=%0d got=%b exp=%b", t, obs(), mdl()); end
            if (key_press[0]) pt = t;
            if (key_long[0]) begin lt = t; nl++; end
        end
        n_cmp += 2;
        if (nl !== 1) begin n_err++; $display("FAIL long_count got=%0d exp=1", nl); end
        if (lt - pt !== LG) begin n_err++; $display("FAIL long_delay got=%0d exp=%0d", lt - pt, LG); end
        key_raw_n[0] = 1'b1;
        for (int t = 1; t <= 9; t++) begin
            tick();
            n_cmp++;
            if (obs() !== mdl()) begin n_err++; $display("FAIL long_rel_model t=%0d got=%b exp=%b", t, obs(), mdl()); end
            if (key_release[0]) rt = t;
        end
        n_cmp++;
        if (rt !== 7) begin n_err++; $display("FAIL long_release got=%0d exp=7", rt); end
        settle();
    endtask
    task automatic test_glitch();
        int nl;
        nl = 0;
        key_raw_n[0] = 1'b0;
        for (int t = 1; t <= 60; t++) begin
            key_raw_n[0] = (t == 13);
            tick();
            n_cmp += 2;
            if (obs() !== mdl()) begin n_err++; $display("FAIL glitch_model t=%0d got=%b exp=%b", t, obs(), mdl()); end
            if (key_release[0] !== 1'b0 || (t >= 7 && key_level[0] !== 1'b1)) begin
                n_err++; $display("FAIL glitch_hold t=%0d rel=%b level=%b", t, key_release[0], key_level[0]);
            end
            if (key_long[0]) nl++;
        end
        n_cmp++;
        if (nl !== 1) begin n_err++; $display("FAIL glitch_long_count got=%0d exp=1", nl); end
        settle();
    endtask
    task automatic test_simultaneous();
        key_raw_n = '0;
        for (int t = 1; t <= 8; t++) begin
            tick();
            n_cmp += 2;
            if (obs() !== mdl()) begin n_err++; $display("FAIL simul_model t=%0d got=%b exp=%b", t, obs(), mdl()); end
            if (key_press !== (t == 7 ? 2'b11 : 2'b00)) begin n_err++; $display("FAIL simul_press t=%0d got=%b", t, key_press); end
        end
        settle();
    endtask
    task automatic test_reset_mid();
        key_raw_n[1] = 1'b0;
        repeat (8) tick();
        key_raw_n[0] = 1'b0;
        repeat (4) tick();
        n_cmp++;
        if (key_level !== 2'b10) begin n_err++; $display("FAIL rmid_pre got=%b exp=10", key_level); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs() !== '0) begin n_err++; $display("FAIL rmid_async got=%b exp=0", obs()); end
        @(negedge clk);
        repeat (2) tick();
        rst_n = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            tick();
            n_cmp += 2;
            if (obs() !== mdl()) begin n_err++; $display("FAIL rmid_model t=%0d got=%b exp=%b", t, obs(), mdl()); end
            if (key_press !== (t == 7 ? 2'b11 : 2'b00)) begin n_err++; $display("FAIL rmid_press t=%0d got=%b", t, key_press); end
        end
        settle();
    endtask
    task automatic test_random();
        int lim;
        for (int i = 0; i < 4000; i++) begin
            lim = ((i / 500) % 2) ? 3 : 30;
            for (int k = 0; k < NK; k++)
                if ($urandom_range(lim - 1, 0) == 0) key_raw_n[k] = ~key_raw_n[k];
            tick();
            n_cmp += 2;
            if (obs() !== mdl()) begin n_err++; $display("FAIL random_model i=%0d got=%b exp=%b", i, obs(), mdl()); end
            if ((key_press & key_release) !== '0) begin n_err++; $display("FAIL random_exclusive i=%0d p=%b r=%b", i, key_press, key_release); end
        end
        settle();
    endtask
    initial begin
        for (int k = 0; k < NK; k++) begin run[k] = 0; hld[k] = 0; end
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_press();
        test_glitch();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
